preg_wb_arbiter: RTL and testbench

PREG_WB_ARBITER -- requirements
Module: preg_wb_arbiter

---
 rtl/preg_wb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_preg_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/preg_wb_arbiter.sv
// preg_wb_arbiter: writeback arbiter that merges results from three execution
// units into two physical register file write ports.
// Each source has a small FIFO. Heads are granted in round-robin scan order,
// with at most two grants per cycle, and the write ports are registered.
// Optional feature: define PREG_WB_PERF_CNT_EN to build the blocked-result
// stall counter. When it is undefined, perf_stall_cnt is tied to zero.
module preg_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [5:0]  src0_preg,
  input  logic [63:0] src0_data,
  input  logic        src1_valid,
  output logic        src1_ready,
  input  logic [5:0]  src1_preg,
  input  logic [63:0] src1_data,
  input  logic        src2_valid,
  output logic        src2_ready,
  input  logic [5:0]  src2_preg,
  input  logic [63:0] src2_data,
  output logic        wren0,
  output logic        wren1,
  output logic [5:0]  waddr0,
  output logic [5:0]  waddr1,
  output logic [63:0] wdata0,
  output logic [63:0] wdata1,
  output logic        wb_idle,
  output logic [31:0] perf_stall_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [2:0]    valid;
  logic [2:0]    ready;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [2:0]    nonempty;
  logic [5:0]    in_preg   [3];
  logic [63:0]   in_data   [3];
  logic [PW-1:0] wr_ptr    [3];
  logic [PW-1:0] rd_ptr    [3];
  logic [CW-1:0] count     [3];
  logic [5:0]    preg_mem  [3][FIFO_DEPTH];
  logic [63:0]   data_mem  [3][FIFO_DEPTH];
  logic [5:0]    head_preg [3];
  logic [63:0]   head_data [3];

  logic [1:0]    rr_ptr;
  logic [1:0]    rr_next;
  logic [1:0]    scan [3];
  logic          g0_v;
  logic          g1_v;
  logic [1:0]    g0_src;
  logic [1:0]    g1_src;
  logic [1:0]    last_src;

  assign valid      = {src2_valid, src1_valid, src0_valid};
  assign in_preg[0] = src0_preg;
  assign in_preg[1] = src1_preg;
  assign in_preg[2] = src2_preg;
  assign in_data[0] = src0_data;
  assign in_data[1] = src1_data;
  assign in_data[2] = src2_data;
  assign src0_ready = ready[0];
  assign src1_ready = ready[1];
  assign src2_ready = ready[2];

  // Per-source status decoded only from registered counts, so ready has no
  // combinational path from any input. Results for preg 0 are accepted and
  // then dropped instead of being enqueued.
  always_comb begin
    ready     = '0;
    nonempty  = '0;
    push      = '0;
    for (int s = 0; s < 3; s++) begin
      head_preg[s] = preg_mem[s][rd_ptr[s]];
      head_data[s] = data_mem[s][rd_ptr[s]];
      ready[s]     = (count[s] < FULL);
      nonempty[s]  = (count[s] != '0);
      push[s]      = valid[s] && ready[s] && (in_preg[s] != 6'd0);
    end
  end

  // FIFO pointers and occupancy. A full FIFO never pushes, even in a cycle
  // in which it pops, because ready is derived from the pre-pop count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // FIFO storage. The contents are only meaningful under count, so they are
  // not reset.
  always_ff @(posedge clock) begin
    for (int s = 0; s < 3; s++) begin
      if (push[s]) begin
        preg_mem[s][wr_ptr[s]] <= in_preg[s];
        data_mem[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // Round-robin scan starting at rr_ptr. The first non-empty head is granted
  // to port 0 and the second to port 1. A third non-empty head waits.
  always_comb begin
    g0_v     = 1'b0;
    g1_v     = 1'b0;
    g0_src   = 2'd0;
    g1_src   = 2'd0;
    pop      = '0;
    scan[0]  = rr_ptr;
    scan[1]  = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    scan[2]  = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (nonempty[scan[k]]) begin
        if (!g0_v) begin
          g0_v   = 1'b1;
          g0_src = scan[k];
        end else if (!g1_v) begin
          g1_v   = 1'b1;
          g1_src = scan[k];
        end
      end
    end
    if (g0_v) pop[g0_src] = 1'b1;
    if (g1_v) pop[g1_src] = 1'b1;
    last_src = g1_v ? g1_src : g0_src;
    rr_next  = (last_src == 2'd2) ? 2'd0 : last_src + 2'd1;
  end

  // Pointer advance: the scan resumes just past the last source served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (g0_v) begin
      rr_ptr <= rr_next;
    end
  end

  // Registered write ports. A port that is not granted drives all zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wren0  <= 1'b0;
      wren1  <= 1'b0;
      waddr0 <= '0;
      waddr1 <= '0;
      wdata0 <= '0;
      wdata1 <= '0;
    end else begin
      wren0  <= g0_v;
      wren1  <= g1_v;
      waddr0 <= g0_v ? head_preg[g0_src] : 6'd0;
      waddr1 <= g1_v ? head_preg[g1_src] : 6'd0;
      wdata0 <= g0_v ? head_data[g0_src] : 64'd0;
      wdata1 <= g1_v ? head_data[g1_src] : 64'd0;
    end
  end

  assign wb_idle = (count[0] == '0) && (count[1] == '0) && (count[2] == '0)
                   && !wren0 && !wren1;

`ifdef PREG_WB_PERF_CNT_EN
  logic stall;
  logic [31:0] stall_cnt;

  assign stall = (|(valid & ~ready)) || (|(nonempty & ~pop));

  // Count cycles in which a result is refused or a buffered head is left
  // waiting. The counter wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_preg_wb_arbiter.sv
// Self-checking bench for preg_wb_arbiter. Expected writes go into a queue
// together with their port and cycle, and a negedge monitor checks them as
// they appear.
module tb_preg_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        src0_valid, src1_valid, src2_valid;
  logic        src0_ready, src1_ready, src2_ready;
  logic [5:0]  src0_preg, src1_preg, src2_preg;
  logic [63:0] src0_data, src1_data, src2_data;
  logic        wren0, wren1;
  logic [5:0]  waddr0, waddr1;
  logic [63:0] wdata0, wdata1;
  logic        wb_idle;
  logic [31:0] perf_stall_cnt;

  typedef struct {
    int          port;
    logic [5:0]  preg;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  preg_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_preg(src0_preg), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_preg(src1_preg), .src1_data(src1_data),
    .src2_valid(src2_valid), .src2_ready(src2_ready), .src2_preg(src2_preg), .src2_data(src2_data),
    .wren0(wren0), .wren1(wren1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .wb_idle(wb_idle), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [63:0] dval(input int p);
    return 64'hD00D_0000_0000_0000 | 64'(p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_push(input int port, input int preg, input logic [63:0] data, input int c);
    wr_t e;
    e.port = port;
    e.preg = 6'(preg);
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_write(input int port, input logic [5:0] a, input logic [63:0] d);
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_write: port %0d addr %0d data 0x%0h at cycle %0d, none expected",
               port, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.port != port || e.preg !== a || e.data !== d || e.cyc != cyc) begin
        errors++;
        $display("FAIL write: got port %0d addr %0d data 0x%0h cycle %0d, expected port %0d addr %0d data 0x%0h cycle %0d",
                 port, a, d, cyc, e.port, e.preg, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: consume expected writes in (cycle, port) order and check that
  // ports without a grant drive zeros.
  always @(negedge clock) begin
    if (!reset) begin
      if (wren0) check_write(0, waddr0, wdata0);
      else chk("idle_port0_zero", {58'd0, waddr0} | wdata0, 64'd0);
      if (wren1) check_write(1, waddr1, wdata1);
      else chk("idle_port1_zero", {58'd0, waddr1} | wdata1, 64'd0);
    end
  end

  task automatic idle_inputs();
    src0_valid = 0; src1_valid = 0; src2_valid = 0;
    src0_preg = 0;  src1_preg = 0;  src2_preg = 0;
    src0_data = 0;  src1_data = 0;  src2_data = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    idle_inputs();
    reset = 1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_perf3;
    int exp_perf2;
    bit r1_tab [4];
    bit r2_tab [4];
    r1_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
    r2_tab = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef PREG_WB_PERF_CNT_EN
    exp_perf2 = 1;
    exp_perf3 = 4;
`else
    exp_perf2 = 0;
    exp_perf3 = 0;
`endif
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_wren0", 64'(wren0), 64'd0);
    chk("rst_wren1", 64'(wren1), 64'd0);
    chk("rst_ready", 64'({src2_ready, src1_ready, src0_ready}), 64'd7);
    chk("rst_idle", 64'(wb_idle), 64'd1);
    chk("rst_perf", 64'(perf_stall_cnt), 64'd0);
    reset = 0;

    // Single push on src1: port 0 write two cycles later
    @(posedge clock); #1;
    n = cyc;
    src1_valid = 1; src1_preg = 6'd5; src1_data = 64'hAA;
    exp_push(0, 5, 64'hAA, n + 2);
    @(posedge clock); #1;
    idle_inputs();
    chk("s1_idle_busy", 64'(wb_idle), 64'd0);
    drain("s1_drain");
    chk("s1_perf", 64'(perf_stall_cnt), 64'd0);
    chk("s1_idle_after", 64'(wb_idle), 64'd1);

    // Three sources push together: 1 on port0, 2 on port1, then 3 on port0
    do_reset();
    @(posedge clock); #1;
    n = cyc;
    src0_valid = 1; src0_preg = 6'd1; src0_data = dval(1);
    src1_valid = 1; src1_preg = 6'd2; src1_data = dval(2);
    src2_valid = 1; src2_preg = 6'd3; src2_data = dval(3);
    exp_push(0, 1, dval(1), n + 2);
    exp_push(1, 2, dval(2), n + 2);
    exp_push(0, 3, dval(3), n + 3);
    @(posedge clock); #1;
    idle_inputs();
    drain("s2_drain");
    chk("s2_perf", 64'(perf_stall_cnt), 64'(exp_perf2));

    // All three valid for 4 cycles: FIFOs fill, and refused payloads are lost
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin
        n = cyc;
        exp_push(0, 10, dval(10), n + 2); exp_push(1, 20, dval(20), n + 2);
        exp_push(0, 30, dval(30), n + 3); exp_push(1, 11, dval(11), n + 3);
        exp_push(0, 21, dval(21), n + 4); exp_push(1, 31, dval(31), n + 4);
        exp_push(0, 12, dval(12), n + 5); exp_push(1, 22, dval(22), n + 5);
        exp_push(0, 33, dval(33), n + 6); exp_push(1, 13, dval(13), n + 6);
      end
      src0_valid = 1; src0_preg = 6'(10 + c); src0_data = dval(10 + c);
      src1_valid = 1; src1_preg = 6'(20 + c); src1_data = dval(20 + c);
      src2_valid = 1; src2_preg = 6'(30 + c); src2_data = dval(30 + c);
      chk($sformatf("s3_ready0_c%0d", c), 64'(src0_ready), 64'd1);
      chk($sformatf("s3_ready1_c%0d", c), 64'(src1_ready), 64'(r1_tab[c]));
      chk($sformatf("s3_ready2_c%0d", c), 64'(src2_ready), 64'(r2_tab[c]));
    end
    @(posedge clock); #1;
    idle_inputs();
    drain("s3_drain");
    chk("s3_perf", 64'(perf_stall_cnt), 64'(exp_perf3));

    // preg 0 is consumed without any write and without leaving idle
    do_reset();
    @(posedge clock); #1;
    src0_valid = 1; src0_preg = 6'd0; src0_data = 64'hFF;
    chk("s4_ready_push", 64'(src0_ready), 64'd1);
    @(posedge clock); #1;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("s4_ready_c%0d", c), 64'(src0_ready), 64'd1);
      chk($sformatf("s4_idle_c%0d", c), 64'(wb_idle), 64'd1);
      @(posedge clock); #1;
    end
    drain("s4_drain");

    // Reset while three entries are buffered
    do_reset();
    @(posedge clock); #1;
    src0_valid = 1; src0_preg = 6'd4; src0_data = dval(4);
    src1_valid = 1; src1_preg = 6'd5; src1_data = dval(5);
    src2_valid = 1; src2_preg = 6'd6; src2_data = dval(6);
    @(posedge clock); #1;
    idle_inputs();
    chk("s5_idle_before", 64'(wb_idle), 64'd0);
    reset = 1;
    #1;
    chk("s5_idle_in_rst", 64'(wb_idle), 64'd1);
    chk("s5_ready_in_rst", 64'({src2_ready, src1_ready, src0_ready}), 64'd7);
    @(posedge clock); #1;
    chk("s5_wren0_rst", 64'(wren0), 64'd0);
    chk("s5_wren1_rst", 64'(wren1), 64'd0);
    reset = 0;
    repeat (5) @(posedge clock);
    #1;
    chk("s5_idle_after", 64'(wb_idle), 64'd1);
    drain("s5_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
